stim_player: RTL and testbench

STIM_PLAYER -- requirements
Module: stim_player

---
 rtl/stim_player_pkg.sv | 20 ++
 rtl/stim_mem.sv | 46 ++++
 rtl/stim_player.sv | 209 ++++++++++++++++++++
 tb/tb_stim_player.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stim_player_pkg.sv
// Shared types and constants for the stimulus player and its entry store.
package stim_player_pkg;

    localparam int unsigned SentCountWidth   = 32;
    localparam int unsigned DefaultLanes     = 8;
    localparam int unsigned DefaultDataWidth = 32;

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StGap
    } state_e;

    // Default-geometry entry; the player builds its own entry type from N and DATA_WIDTH.
    typedef struct packed {
        logic [DefaultLanes-1:0][DefaultDataWidth-1:0] vector;
        logic [1:0]                                    eof;
    } entry_t;

endpackage

// File: rtl/stim_mem.sv
// Stimulus entry store: register array, one write port, registered read port.
// A same-cycle write and read of one entry returns the old contents.
module stim_mem
    import stim_player_pkg::*;
#(
    parameter int unsigned Depth = 32,
    parameter type entry_type_t = entry_t
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en_i,
    input  logic [$clog2(Depth)-1:0] wr_addr_i,
    input  entry_type_t              wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(Depth)-1:0] rd_addr_i,
    output entry_type_t              rd_data_o
);

    entry_type_t mem_q [Depth];
    entry_type_t rd_data_q, rd_data_d;

    // Contents survive reset; writes are blocked while reset is high.
    always_ff @(posedge clk) begin
        if (wr_en_i && !reset) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            rd_data_d = mem_q[rd_addr_i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/stim_player.sv
// Plays stored stimulus vectors out with optional idle gaps and looping.
// Define STIM_PLAYER_CHECKSUM_EN to add a running XOR checksum output.
module stim_player
    import stim_player_pkg::*;
#(
    parameter int unsigned N          = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned GAP_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [$clog2(DEPTH)-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_vector [N],
    input  logic [1:0]                wr_eof,
    input  logic                      start,
    input  logic                      stop,
    input  logic [$clog2(DEPTH):0]    length,
    input  logic [GAP_WIDTH-1:0]      gap,
    input  logic                      loop,
    output logic [DATA_WIDTH-1:0]     vector_out [N],
    output logic                      enqueue,
    output logic [1:0]                eof_out,
    output logic                      busy,
    output logic [SentCountWidth-1:0] sent_count,
`ifdef STIM_PLAYER_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0]     checksum,
    output logic                      done
`else
    output logic                      done
`endif
);

    localparam int unsigned AddrWidth = $clog2(DEPTH);
    localparam int unsigned LenWidth  = AddrWidth + 1;
    localparam logic [LenWidth-1:0] DepthLen = LenWidth'(DEPTH);

    typedef struct packed {
        logic [N-1:0][DATA_WIDTH-1:0] vector;
        logic [1:0]                   eof;
    } lane_entry_t;

    state_e                    state_q, state_d;
    logic [AddrWidth-1:0]      ptr_q, ptr_d;
    logic [LenWidth-1:0]       len_q, len_d;
    logic [GAP_WIDTH-1:0]      gap_q, gap_d;
    logic [GAP_WIDTH-1:0]      gap_cnt_q, gap_cnt_d;
    logic                      loop_q, loop_d;
    logic                      done_q, done_d;
    logic [SentCountWidth-1:0] sent_q, sent_d;

    logic                 accept;
    logic                 last_entry;
    logic [AddrWidth-1:0] next_ptr;
    logic                 rd_en;
    logic [AddrWidth-1:0] rd_addr;
    lane_entry_t          wr_entry;
    lane_entry_t          rd_entry;

    always_comb begin
        wr_entry.eof = wr_eof;
        for (int i = 0; i < N; i++) begin
            wr_entry.vector[i] = wr_vector[i];
        end
    end

    // The read register doubles as the vector_out/eof_out output register.
    stim_mem #(
        .Depth        (DEPTH),
        .entry_type_t (lane_entry_t)
    ) u_mem (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_entry),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_entry)
    );

    assign accept     = (state_q == StIdle) && start && !stop && (length != '0);
    assign last_entry = ({1'b0, ptr_q} == (len_q - LenWidth'(1)));
    assign next_ptr   = last_entry ? '0 : ptr_q + AddrWidth'(1);

    // In PLAY ptr_q is the entry on the outputs; in GAP it is the next entry to emit.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        len_d     = len_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        loop_d    = loop_q;
        done_d    = 1'b0;
        sent_d    = sent_q;
        rd_en     = 1'b0;
        rd_addr   = '0;

        if (state_q == StPlay && sent_q != '1) begin
            sent_d = sent_q + SentCountWidth'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StPlay;
                    ptr_d   = '0;
                    len_d   = (length > DepthLen) ? DepthLen : length;
                    gap_d   = gap;
                    loop_d  = loop;
                    sent_d  = '0;
                    rd_en   = 1'b1;
                end
            end
            StPlay: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (last_entry && !loop_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    ptr_d = next_ptr;
                    if (gap_q != '0) begin
                        state_d   = StGap;
                        gap_cnt_d = gap_q;
                    end else begin
                        rd_en   = 1'b1;
                        rd_addr = next_ptr;
                    end
                end
            end
            StGap: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (gap_cnt_q == GAP_WIDTH'(1)) begin
                    state_d = StPlay;
                    rd_en   = 1'b1;
                    rd_addr = ptr_q;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            loop_q    <= 1'b0;
            done_q    <= 1'b0;
            sent_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            loop_q    <= loop_d;
            done_q    <= done_d;
            sent_q    <= sent_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            vector_out[i] = rd_entry.vector[i];
        end
        eof_out    = rd_entry.eof;
        enqueue    = (state_q == StPlay);
        busy       = (state_q != StIdle);
        done       = done_q;
        sent_count = sent_q;
    end

`ifdef STIM_PLAYER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
    logic [DATA_WIDTH-1:0] lane_xor;

    always_comb begin
        lane_xor = '0;
        for (int i = 0; i < N; i++) begin
            lane_xor = lane_xor ^ rd_entry.vector[i];
        end
        checksum_d = checksum_q;
        if (accept) begin
            checksum_d = '0;
        end else if (state_q == StPlay) begin
            checksum_d = checksum_q ^ lane_xor;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_stim_player.sv
// Randomised scoreboard bench for stim_player; the expected emit stream is derived
// from the stored-entry image and the playback rules, then checked by a monitor.
module tb_stim_player;

    localparam int unsigned N     = 8;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned GW    = 8;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned VW    = N * DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_vector [N];
    logic [1:0]    wr_eof;
    logic          start;
    logic          stop;
    logic [AW:0]   length;
    logic [GW-1:0] gap;
    logic          loop;
    logic [DW-1:0] vector_out [N];
    logic          enqueue;
    logic [1:0]    eof_out;
    logic          busy;
    logic [31:0]   sent_count;
    logic          done;
`ifdef STIM_PLAYER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    always #5 clk = ~clk;

    stim_player #(
        .N          (N),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .GAP_WIDTH  (GW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_vector  (wr_vector),
        .wr_eof     (wr_eof),
        .start      (start),
        .stop       (stop),
        .length     (length),
        .gap        (gap),
        .loop       (loop),
        .vector_out (vector_out),
        .enqueue    (enqueue),
        .eof_out    (eof_out),
        .busy       (busy),
        .sent_count (sent_count),
`ifdef STIM_PLAYER_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .done       (done)
    );

    typedef struct {
        int            t;
        logic [VW-1:0] vec;
        logic [1:0]    eof;
    } emit_t;

    emit_t         emit_q [$];
    int            done_q [$];
    logic [VW-1:0] mem_vec [DEPTH];
    logic [1:0]    mem_eof [DEPTH];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] packed_out();
        logic [VW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = vector_out[i];
        return v;
    endfunction

    // Monitor: every enqueue and done pulse must match the head of its queue.
    always @(negedge clk) begin
        emit_t e;
        int    dt;
        if (enqueue) begin
            chk("emit_expected", VW'(emit_q.size() > 0), VW'(1));
            if (emit_q.size() > 0) begin
                e = emit_q.pop_front();
                chk("emit_cycle", VW'(cyc), VW'(e.t));
                chk("emit_vector", packed_out(), e.vec);
                chk("emit_eof", VW'(eof_out), VW'(e.eof));
            end
        end
        if (done) begin
            chk("done_expected", VW'(done_q.size() > 0), VW'(1));
            if (done_q.size() > 0) begin
                dt = done_q.pop_front();
                chk("done_cycle", VW'(cyc), VW'(dt));
            end
        end
    end

    task automatic wr(input int a, input logic [VW-1:0] v, input logic [1:0] e);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        for (int i = 0; i < N; i++) wr_vector[i] = v[i*DW +: DW];
        wr_eof  = e;
        tick();
        wr_en   = 1'b0;
        mem_vec[a] = v;
        mem_eof[a] = e;
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = $urandom;
        return v;
    endfunction

    // One playback. stop_off < 0 means no stop; otherwise stop is high in cycle start+stop_off.
    task automatic run(input int len, input int g, input bit lp, input int stop_off);
        int            c, l, last_t, end_t, n;
        bit            stopped, saw_busy;
        logic [DW-1:0] cks;
        emit_t         e;
        l = (len > int'(DEPTH)) ? int'(DEPTH) : len;
        length = (AW+1)'(len);
        gap    = GW'(g);
        loop   = lp;
        start  = 1'b1;
        c      = cyc;
        n      = 0;
        cks    = '0;
        end_t  = c + 1;
        if (l != 0) begin
            last_t  = c + 1 + (l - 1) * (g + 1);
            stopped = (stop_off >= 0) && (lp || (c + stop_off <= last_t));
            for (int k = 0; k < 100000; k++) begin
                e.t = c + 1 + k * (g + 1);
                if (!lp && k >= l) break;
                if (stop_off >= 0 && e.t > c + stop_off) break;
                e.vec = mem_vec[k % l];
                e.eof = mem_eof[k % l];
                emit_q.push_back(e);
                n++;
                for (int i = 0; i < N; i++) cks = cks ^ e.vec[i*DW +: DW];
            end
            if (stopped) begin
                end_t = c + stop_off + 1;
            end else begin
                done_q.push_back(last_t + 1);
                end_t = last_t + 1;
            end
        end
        tick();
        // Second start cycle with scrambled settings: must be ignored while playing.
        if (l == 0) begin
            length = '0;
        end else begin
            length = (AW+1)'($urandom);
            gap    = GW'($urandom);
            loop   = 1'($urandom);
        end
        stop     = (stop_off == 1);
        saw_busy = busy;
        while (cyc < end_t + 2) begin
            tick();
            start = 1'b0;
            stop  = (stop_off >= 0) && (cyc == c + stop_off);
            if (busy) saw_busy = 1'b1;
        end
        stop = 1'b0;
        chk("idle_busy", VW'(busy), VW'(0));
        chk("idle_enqueue", VW'(enqueue), VW'(0));
        chk("emits_drained", VW'(emit_q.size()), VW'(0));
        chk("done_drained", VW'(done_q.size()), VW'(0));
        emit_q.delete();
        done_q.delete();
        if (l == 0) begin
            chk("zero_len_busy", VW'(saw_busy), VW'(0));
        end else begin
            chk("sent_count", VW'(sent_count), VW'(n));
`ifdef STIM_PLAYER_CHECKSUM_EN
            chk("checksum", VW'(checksum), VW'(cks));
`endif
        end
    endtask

    initial begin
        logic [VW-1:0] v;
        int            c, len, g, so;
        bit            lp;
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_eof  = '0;
        for (int i = 0; i < N; i++) wr_vector[i] = '0;
        start   = 1'b0;
        stop    = 1'b0;
        length  = '0;
        gap     = '0;
        loop    = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_enqueue", VW'(enqueue), VW'(0));
        chk("rst_busy", VW'(busy), VW'(0));
        chk("rst_done", VW'(done), VW'(0));
        chk("rst_eof", VW'(eof_out), VW'(0));
        chk("rst_vector", packed_out(), VW'(0));
        chk("rst_sent", VW'(sent_count), VW'(0));

        for (int a = 0; a < int'(DEPTH); a++) wr(a, rand_vec(), 2'($urandom));

        v = rand_vec(); v[DW-1:0] = 359670; wr(0, v, 2'b00);
        v = rand_vec(); v[DW-1:0] = 631546; wr(1, v, 2'b00);
        v = rand_vec(); v[DW-1:0] = 13250;  wr(2, v, 2'b01);
        run(3, 0, 1'b0, -1);
        run(3, 2, 1'b0, -1);
        run(2, 0, 1'b1, 4);
        run(0, 0, 1'b0, -1);
        run(40, 0, 1'b0, -1);

        // Reset in cycle start+2, with start held and a write attempted: both must be ignored.
        length = 3; gap = 0; loop = 1'b0; start = 1'b1; c = cyc;
        for (int k = 0; k < 2; k++) emit_q.push_back('{c + 1 + k, mem_vec[k], mem_eof[k]});
        tick();
        tick();
        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 1;
        for (int i = 0; i < N; i++) wr_vector[i] = $urandom;
        tick();
        reset = 1'b0;
        wr_en = 1'b0;
        start = 1'b0;
        chk("midrst_enqueue", VW'(enqueue), VW'(0));
        chk("midrst_busy", VW'(busy), VW'(0));
        chk("midrst_done", VW'(done), VW'(0));
        chk("midrst_eof", VW'(eof_out), VW'(0));
        chk("midrst_vector", packed_out(), VW'(0));
        chk("midrst_sent", VW'(sent_count), VW'(0));
        tick();
        chk("midrst_drained", VW'(emit_q.size()), VW'(0));
        emit_q.delete();
        run(3, 0, 1'b0, -1);

`ifdef STIM_PLAYER_CHECKSUM_EN
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(i + 1);
        wr(0, v, 2'b00);
        run(1, 0, 1'b0, -1);
`endif

        for (int r = 0; r < 25; r++) begin
            repeat ($urandom_range(0, 4)) wr($urandom_range(0, DEPTH - 1), rand_vec(), 2'($urandom));
            len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, DEPTH + 8);
            g   = ($urandom_range(0, 5) == 0) ? 5 : $urandom_range(0, 3);
            lp  = 1'($urandom);
            so  = -1;
            if (lp) begin
                so = $urandom_range(1, 3 * len * (g + 1) + 2);
            end else if ($urandom_range(0, 3) == 0) begin
                so = $urandom_range(1, len * (g + 1) + 1);
            end
            run(len, g, lp, so);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
